interleaver_stream: RTL and testbench

Parametrised, streaming 802.11a bit interleaver/deinterleaver for all four modulation rates, replacing the single-symbol, fixed-rate first-permutation block. It takes coded bits one per clock from the convolutional encoder/puncturer, applies both standard permutations (or their inverse in deinterleave mode), and streams the symbol out in permuted order toward the mapper. Two ping-pong symbol banks give continuous 1 bit/clock throughput with valid/ready flow control on both sides.

---
 rtl/interleaver_stream.sv | 199 +++++++++++++++++++
 tb/tb_interleaver_stream.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interleaver_stream.sv
// interleaver_stream: streaming 802.11a two-permutation bit interleaver/deinterleaver with ping-pong symbol banks
module interleaver_stream #(
    parameter int N_SD  = 48,
    parameter int N_COL = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mod_sel,
    input  logic       deint,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last
);
    localparam int NCBPS_MAX = 6 * N_SD;
    localparam int AW = $clog2(NCBPS_MAX);
    localparam int CW = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam logic [AW-1:0] ONE = AW'(1);

    function automatic int nbpsc_f(input logic [1:0] m);
        return (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 6;
    endfunction

    function automatic logic [AW-1:0] ncbps_f(input logic [1:0] m);
        return AW'(N_SD * nbpsc_f(m));
    endfunction

    function automatic logic [AW-1:0] nrows_f(input logic [1:0] m);
        return AW'((N_SD / N_COL) * nbpsc_f(m));
    endfunction

    function automatic logic [1:0] s_f(input logic [1:0] m);
        return (m == 2'd3) ? 2'd3 : (m == 2'd2) ? 2'd2 : 2'd1;
    endfunction

    function automatic logic [1:0] inc_mod(input logic [1:0] v, input logic [1:0] s);
        return (v + 2'd1 == s) ? 2'd0 : v + 2'd1;
    endfunction

    // write-side counters: n is the symbol index; col/row/iacc walk the interleave
    // row/column grid (iacc = first-permutation index i); p/q walk the deinterleave grid
    // (p = j mod rows, q = j div rows); the *_r registers hold residues modulo s
    logic [AW-1:0] n_q, n_d, row_q, row_d, iacc_q, iacc_d, p_q, p_d;
    logic [CW-1:0] col_q, col_d, q_q, q_d;
    logic [1:0]    rr_q, rr_d, cr_q, cr_d, jr_q, jr_d, qr_q, qr_d;
    logic [1:0]    wmod_q, wmod_d;
    logic          wdei_q, wdei_d;
    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0][1:0] bmod_q;
    logic [NCBPS_MAX-1:0] mem_q [2];

    logic          first, dei_e, wr_fire, wr_last, rd_fire;
    logic [1:0]    mod_e, s_e, t_il, t_dl;
    logic [2:0]    sum_dl;
    logic [AW-1:0] nrows_e, addr_il, pi_dl, addr_dl, waddr, rd_ncbps;

    // the first bit of a symbol uses the live mode inputs, later bits the captured ones
    assign first   = (n_q == '0);
    assign mod_e   = first ? mod_sel : wmod_q;
    assign dei_e   = first ? deint : wdei_q;
    assign s_e     = s_f(mod_e);
    assign nrows_e = nrows_f(mod_e);
    assign in_ready = ~full_q[wr_bank_q];
    assign wr_fire = in_valid & in_ready;
    assign wr_last = (n_q == ncbps_f(mod_e) - ONE);

    // interleave: rows are multiples of s, so i mod s is constant along a column
    // sweep and equals row mod s; the second-permutation shift reduces to (rr - col) mod s
    assign t_il    = (rr_q >= cr_q) ? rr_q - cr_q : rr_q + s_e - cr_q;
    assign addr_il = iacc_q - AW'(rr_q) + AW'(t_il);

    // deinterleave: i stays in the same s-group as j, so i div rows == q and
    // k = N_COL*(i mod rows) + q with i mod rows = p - (j mod s) + ((j + q) mod s)
    assign sum_dl  = {1'b0, jr_q} + {1'b0, qr_q};
    assign t_dl    = (sum_dl >= {1'b0, s_e}) ? 2'(sum_dl - {1'b0, s_e}) : 2'(sum_dl);
    assign pi_dl   = p_q - AW'(jr_q) + AW'(t_dl);
    assign addr_dl = pi_dl * AW'(N_COL) + AW'(q_q);
    assign waddr   = dei_e ? addr_dl : addr_il;

    assign rd_ncbps  = ncbps_f(bmod_q[rd_bank_q]);
    assign out_valid = full_q[rd_bank_q];
    assign out_last  = out_valid & (rd_cnt_q == rd_ncbps - ONE);
    assign out_bit   = out_valid & mem_q[rd_bank_q][rd_cnt_q];
    assign rd_fire   = out_valid & out_ready;

    // advance the write-address counters on every accepted bit, clearing at symbol end
    always_comb begin
        n_d = n_q;
        row_d = row_q;
        iacc_d = iacc_q;
        p_d = p_q;
        col_d = col_q;
        q_d = q_q;
        rr_d = rr_q;
        cr_d = cr_q;
        jr_d = jr_q;
        qr_d = qr_q;
        wmod_d = wmod_q;
        wdei_d = wdei_q;
        if (wr_fire) begin
            wmod_d = mod_e;
            wdei_d = dei_e;
            if (wr_last) begin
                n_d = '0;
                row_d = '0;
                iacc_d = '0;
                p_d = '0;
                col_d = '0;
                q_d = '0;
                rr_d = '0;
                cr_d = '0;
                jr_d = '0;
                qr_d = '0;
            end else begin
                n_d = n_q + ONE;
                jr_d = inc_mod(jr_q, s_e);
                if (p_q == nrows_e - ONE) begin
                    p_d = '0;
                    q_d = q_q + CW'(1);
                    qr_d = inc_mod(qr_q, s_e);
                end else begin
                    p_d = p_q + ONE;
                end
                if (col_q == CW'(N_COL - 1)) begin
                    col_d = '0;
                    row_d = row_q + ONE;
                    iacc_d = row_q + ONE;
                    rr_d = inc_mod(rr_q, s_e);
                    cr_d = '0;
                end else begin
                    col_d = col_q + CW'(1);
                    iacc_d = iacc_q + nrows_e;
                    cr_d = inc_mod(cr_q, s_e);
                end
            end
        end
    end

    // ping-pong bookkeeping: fill flags, bank pointers and the sequential read address
    always_comb begin
        full_d = full_q;
        if (wr_fire && wr_last) full_d[wr_bank_q] = 1'b1;
        if (rd_fire && out_last) full_d[rd_bank_q] = 1'b0;
        wr_bank_d = wr_bank_q ^ (wr_fire & wr_last);
        rd_bank_d = rd_bank_q ^ (rd_fire & out_last);
        rd_cnt_d = rd_fire ? (out_last ? '0 : rd_cnt_q + ONE) : rd_cnt_q;
    end

    // control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q <= '0;
            row_q <= '0;
            iacc_q <= '0;
            p_q <= '0;
            col_q <= '0;
            q_q <= '0;
            rr_q <= '0;
            cr_q <= '0;
            jr_q <= '0;
            qr_q <= '0;
            wmod_q <= '0;
            wdei_q <= 1'b0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q <= '0;
            rd_cnt_q <= '0;
            bmod_q <= '0;
        end else begin
            n_q <= n_d;
            row_q <= row_d;
            iacc_q <= iacc_d;
            p_q <= p_d;
            col_q <= col_d;
            q_q <= q_d;
            rr_q <= rr_d;
            cr_q <= cr_d;
            jr_q <= jr_d;
            qr_q <= qr_d;
            wmod_q <= wmod_d;
            wdei_q <= wdei_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q <= full_d;
            rd_cnt_q <= rd_cnt_d;
            if (wr_fire && first) bmod_q[wr_bank_q] <= mod_sel;
        end
    end

    // symbol storage is never cleared; only the fill flags qualify its contents
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_bank_q][waddr] <= in_bit;
    end
endmodule

// File: tb/tb_interleaver_stream.sv
// tb_interleaver_stream: randomized scoreboard bench for interleaver_stream against a formula-level permutation model
module tb_interleaver_stream;
    localparam int N_SD  = 48;
    localparam int N_COL = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] mod_sel = 2'd0;
    logic deint = 1'b0, in_bit = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_bit, out_valid, out_last;

    int checks = 0, failures = 0, stalls = 0, idx = 0, last_len = 0;
    bit [1:0] exp_q[$];
    bit sym[288];
    bit cur[288];
    bit last_sym[288];
    bit orig[288];
    bit rnd_ready = 1'b0, gaps = 1'b0;

    interleaver_stream #(.N_SD(N_SD), .N_COL(N_COL)) dut (
        .clk(clk), .reset(reset), .mod_sel(mod_sel), .deint(deint),
        .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
        .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic int nb_f(int m);
        return (m == 0) ? 1 : (m == 1) ? 2 : (m == 2) ? 4 : 6;
    endfunction

    // bank address where input index n lands, straight from the standard's formulas
    function automatic int perm(int n, int m, bit d);
        int nc, s, i, j, k;
        nc = N_SD * nb_f(m);
        s = (nb_f(m) / 2 > 1) ? nb_f(m) / 2 : 1;
        if (!d) begin
            k = n;
            i = (nc / N_COL) * (k % N_COL) + k / N_COL;
            j = s * (i / s) + (i + nc - (N_COL * i / nc)) % s;
            return j;
        end
        j = n;
        i = s * (j / s) + (j + (N_COL * j / nc)) % s;
        k = N_COL * i - (nc - 1) * (N_COL * i / nc);
        return k;
    endfunction

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic put(input bit b, input int m, input bit d);
        int t = 0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_bit = b;
        mod_sel = 2'(m);
        deint = d;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready || t > 3000) break;
            stalls++;
            t++;
        end
        if (t > 3000) begin
            failures++;
            $display("FAIL in_timeout: in_ready stuck at %0d want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // mode inputs are scrambled after the first bit; the DUT must ignore them
    task automatic send_sym(input int m, input bit d);
        int nc;
        bit e[288];
        nc = N_SD * nb_f(m);
        for (int n = 0; n < nc; n++)
            put(sym[n], (n == 0) ? m : int'($urandom_range(0, 3)), (n == 0) ? d : bit'($urandom_range(0, 1)));
        for (int n = 0; n < nc; n++) e[perm(n, m, d)] = sym[n];
        for (int a = 0; a < nc; a++) exp_q.push_back({a == nc - 1, e[a]});
    endtask

    task automatic rand_sym();
        for (int n = 0; n < 288; n++) sym[n] = bit'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: pending %0d want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int ones(int len);
        int c = 0;
        for (int a = 0; a < len; a++) c += int'(last_sym[a]);
        return c;
    endfunction

    function automatic int hi_pos(int len);
        for (int a = 0; a < len; a++) if (last_sym[a]) return a;
        return -1;
    endfunction

    task automatic single_one(input int m, input int want_pos, input string name);
        for (int n = 0; n < 288; n++) sym[n] = 1'b0;
        sym[1] = 1'b1;
        send_sym(m, 1'b0);
        @(negedge clk);
        chk({name, "_latency"}, out_valid, 1);
        drain();
        chk({name, "_len"}, last_len, N_SD * nb_f(m));
        chk({name, "_ones"}, ones(last_len), 1);
        chk({name, "_pos"}, hi_pos(last_len), want_pos);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // monitor: pops the scoreboard on every output transfer and checks hold/idle rules
    initial begin
        bit hv = 1'b0, hb = 1'b0, hl = 1'b0;
        bit [1:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                idx = 0;
                hv = 1'b0;
            end else begin
                chk("valid_vs_pending", out_valid, exp_q.size() != 0);
                if (!out_valid) chk("idle_outputs", {out_bit, out_last}, 0);
                if (hv) chk("held_outputs", {out_valid, out_bit, out_last}, {1'b1, hb, hl});
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_bit", out_bit, e[0]);
                    chk("out_last", out_last, e[1]);
                    cur[idx] = out_bit;
                    if (out_last) begin
                        last_sym = cur;
                        last_len = idx + 1;
                        idx = 0;
                    end else if (idx < 287) begin
                        idx++;
                    end
                end
                hv = out_valid && !out_ready;
                hb = out_bit;
                hl = out_last;
            end
        end
    end

    initial begin
        logic [191:0] v;
        int diff, t;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bit", out_bit, 0);
        chk("rst_out_last", out_last, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;

        single_one(0, 3, "bpsk");
        single_one(2, 13, "qam16");
        single_one(3, 20, "qam64");

        v = 192'h4dd7cb079807c203ce1303f14317df52b859adb90f8510d4;
        for (int n = 0; n < 192; n++) begin
            sym[n] = v[191 - n];
            orig[n] = v[191 - n];
        end
        send_sym(2, 1'b0);
        drain();
        for (int n = 0; n < 192; n++) sym[n] = last_sym[n];
        send_sym(2, 1'b1);
        drain();
        diff = 0;
        for (int n = 0; n < 192; n++) diff += int'(last_sym[n] != orig[n]);
        chk("roundtrip_diff", diff, 0);
        chk("roundtrip_len", last_len, 192);

        @(posedge clk);
        #1 out_ready = 1'b0;
        rand_sym();
        send_sym(1, 1'b0);
        rand_sym();
        send_sym(1, 1'b1);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(out_valid && out_last) && t < 500);
        chk("bp_in_ready_at_last", in_ready, 0);
        @(negedge clk);
        chk("bp_in_ready_after", in_ready, 1);
        drain();

        stalls = 0;
        rand_sym();
        send_sym(0, 1'b0);
        rand_sym();
        send_sym(1, 1'b0);
        rand_sym();
        send_sym(3, 1'b0);
        rand_sym();
        send_sym(3, 1'b1);
        rand_sym();
        send_sym(3, 1'b0);
        chk("continuous_stalls", stalls, 0);
        drain();

        rand_sym();
        for (int n = 0; n < 100; n++) put(sym[n], 2, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rand_sym();
        send_sym(2, 1'b1);
        drain();
        chk("midrst_len", last_len, 192);

        gaps = 1'b1;
        rnd_ready = 1'b1;
        repeat (8) begin
            rand_sym();
            send_sym(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end
        gaps = 1'b0;
        drain();
        rnd_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
